// File: rtl/instr_fsm.sv
// -----------------------------------------------------------------------------
// instr_fsm
//
// Multi-cycle control sequencer for the simple 16-bit RISC datapath. When a
// start request is accepted in WAIT, the instruction's opcode and op fields are
// captured. The FSM then steps through register-file reads into the A/B operand
// registers, the ALU compute or compare cycle, and register write-back. All
// outputs are Moore outputs, decoded from the current state and the captured
// instruction fields.
//
// Ports:
//   clk      in   1  rising-edge clock
//   reset    in   1  synchronous, active-high; returns the FSM to WAIT
//   s        in   1  start request, honoured only in WAIT
//   opcode   in   3  instruction bits [15:13], captured when s is accepted
//   op       in   2  instruction bits [12:11], captured when s is accepted
//   w        out  1  idle in WAIT and ready for s
//   nsel     out  3  one-hot register select: 001=Rn, 010=Rd, 100=Rm
//   vsel     out  2  write-back source: 00=C register, 01=sign-extended imm8
//   write    out  1  register-file write enable
//   loada    out  1  load A operand register
//   loadb    out  1  load B operand register
//   asel     out  1  force ALU A input to zero
//   bsel     out  1  shifted-B path select (unused by this ISA subset, tied 0)
//   loadc    out  1  load C result register
//   loads    out  1  load status (Z) register
//   alu_op   out  2  ALU op: 00 add, 01 sub, 10 and, 11 not-B
// -----------------------------------------------------------------------------
module instr_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       asel,
    output logic       bsel,
    output logic       loadc,
    output logic       loads,
    output logic [1:0] alu_op
);

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_DECODE,
        ST_WRITE_IMM,
        ST_GET_A,
        ST_GET_B,
        ST_COMPUTE,
        ST_CMP_S,
        ST_WRITE_REG
    } state_e;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_CMP = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MVN = 2'b11;
    localparam logic [1:0] OP_IMM = 2'b10;   // MOV Rn,#imm8 under OPC_MOV
    localparam logic [1:0] OP_REG = 2'b00;   // MOV Rd,Rm under OPC_MOV

    localparam logic [2:0] NSEL_RN = 3'b001;
    localparam logic [2:0] NSEL_RD = 3'b010;
    localparam logic [2:0] NSEL_RM = 3'b100;

    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b01;

    state_e     state_q, state_d;
    logic [2:0] opcode_q;
    logic [1:0] op_q;
    logic       accept;

    // The instruction is captured only when a start request meets an idle FSM.
    assign accept = (state_q == ST_WAIT) && s;

    // -------------------------------------------------------------------------
    // State and instruction registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_WAIT;
            opcode_q <= 3'b000;
            op_q     <= 2'b00;
        end else begin
            state_q <= state_d;
            if (accept) begin
                opcode_q <= opcode;
                op_q     <= op;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_WAIT: begin
                if (s) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                case ({opcode_q, op_q})
                    {OPC_MOV, OP_IMM}: state_d = ST_WRITE_IMM;
                    {OPC_MOV, OP_REG},
                    {OPC_ALU, OP_MVN}: state_d = ST_GET_B;
                    {OPC_ALU, OP_ADD},
                    {OPC_ALU, OP_AND},
                    {OPC_ALU, OP_CMP}: state_d = ST_GET_A;
                    default:           state_d = ST_WAIT;
                endcase
            end
            ST_GET_A: state_d = ST_GET_B;
            ST_GET_B: begin
                // CMP only updates status; everything else produces a result.
                if (opcode_q == OPC_ALU && op_q == OP_CMP) state_d = ST_CMP_S;
                else                                       state_d = ST_COMPUTE;
            end
            ST_COMPUTE:   state_d = ST_WRITE_REG;
            ST_WRITE_IMM,
            ST_CMP_S,
            ST_WRITE_REG: state_d = ST_WAIT;
            default:      state_d = ST_WAIT;
        endcase
    end

    // -------------------------------------------------------------------------
    // Moore output decode
    // -------------------------------------------------------------------------
    always_comb begin
        w      = 1'b0;
        nsel   = 3'b000;
        vsel   = VSEL_C;
        write  = 1'b0;
        loada  = 1'b0;
        loadb  = 1'b0;
        asel   = 1'b0;
        bsel   = 1'b0;
        loadc  = 1'b0;
        loads  = 1'b0;
        alu_op = OP_ADD;
        unique case (state_q)
            ST_WAIT: w = 1'b1;
            ST_DECODE: ;
            ST_WRITE_IMM: begin
                nsel  = NSEL_RN;
                vsel  = VSEL_IMM;
                write = 1'b1;
            end
            ST_GET_A: begin
                nsel  = NSEL_RN;
                loada = 1'b1;
            end
            ST_GET_B: begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
            end
            ST_COMPUTE: begin
                loadc  = 1'b1;
                // MOV Rd,Rm is ADD with A forced to zero; MVN ignores A too.
                asel   = (opcode_q == OPC_MOV) ||
                         (opcode_q == OPC_ALU && op_q == OP_MVN);
                alu_op = op_q;
            end
            ST_CMP_S: begin
                loads  = 1'b1;
                alu_op = OP_CMP;
            end
            ST_WRITE_REG: begin
                nsel  = NSEL_RD;
                vsel  = VSEL_C;
                write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_instr_fsm.sv
// -----------------------------------------------------------------------------
// tb_instr_fsm
//
// Directed bench for instr_fsm. Outputs are packed into one 15-bit vector
// {w, nsel, vsel, write, loada, loadb, asel, bsel, loadc, loads, alu_op}
// and compared against hand-written per-state constants. Inputs change and
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_instr_fsm;

    logic       clk;
    logic       reset;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       asel;
    logic       bsel;
    logic       loadc;
    logic       loads;
    logic [1:0] alu_op;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected output vectors, one per state (COMPUTE varies by instruction).
    localparam logic [14:0] E_WAIT     = {1'b1, 3'b000, 2'b00, 1'b0, 6'b000000, 2'b00};
    localparam logic [14:0] E_DECODE   = {1'b0, 3'b000, 2'b00, 1'b0, 6'b000000, 2'b00};
    localparam logic [14:0] E_WIMM     = {1'b0, 3'b001, 2'b01, 1'b1, 6'b000000, 2'b00};
    localparam logic [14:0] E_GETA     = {1'b0, 3'b001, 2'b00, 1'b0, 6'b100000, 2'b00};
    localparam logic [14:0] E_GETB     = {1'b0, 3'b100, 2'b00, 1'b0, 6'b010000, 2'b00};
    localparam logic [14:0] E_COMP_ADD = {1'b0, 3'b000, 2'b00, 1'b0, 6'b000010, 2'b00};
    localparam logic [14:0] E_COMP_AND = {1'b0, 3'b000, 2'b00, 1'b0, 6'b000010, 2'b10};
    localparam logic [14:0] E_COMP_MOV = {1'b0, 3'b000, 2'b00, 1'b0, 6'b001010, 2'b00};
    localparam logic [14:0] E_COMP_MVN = {1'b0, 3'b000, 2'b00, 1'b0, 6'b001010, 2'b11};
    localparam logic [14:0] E_CMPS     = {1'b0, 3'b000, 2'b00, 1'b0, 6'b000001, 2'b01};
    localparam logic [14:0] E_WREG     = {1'b0, 3'b010, 2'b00, 1'b1, 6'b000000, 2'b00};

    instr_fsm dut (
        .clk    (clk),
        .reset  (reset),
        .s      (s),
        .opcode (opcode),
        .op     (op),
        .w      (w),
        .nsel   (nsel),
        .vsel   (vsel),
        .write  (write),
        .loada  (loada),
        .loadb  (loadb),
        .asel   (asel),
        .bsel   (bsel),
        .loadc  (loadc),
        .loads  (loads),
        .alu_op (alu_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] obs();
        return {w, nsel, vsel, write, loada, loadb, asel, bsel, loadc, loads, alu_op};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present an instruction with s=1 for one edge; returns on the falling
    // edge after the sampling edge (FSM in DECODE if it was in WAIT).
    task automatic issue(input logic [2:0] opc, input logic [1:0] opf);
        opcode = opc;
        op     = opf;
        s      = 1'b1;
        step();
        s      = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        s      = 1'b1;
        opcode = 3'b110;
        op     = 2'b10;
        step();
        step();
        n_checks++;
        if (obs() !== E_WAIT) begin
            n_fail++;
            $display("FAIL reset_with_s: got %b expected %b", obs(), E_WAIT);
        end
        reset = 1'b0;
        s     = 1'b0;
        step();
        n_checks++;
        if (obs() !== E_WAIT) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b expected %b", obs(), E_WAIT);
        end
    endtask

    task automatic test_mov_imm();
        logic [14:0] exp_v [3] = '{E_DECODE, E_WIMM, E_WAIT};
        issue(3'b110, 2'b10);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs() !== exp_v[i]) begin
                n_fail++;
                $display("FAIL mov_imm[%0d]: got %b expected %b", i, obs(), exp_v[i]);
            end
            if (i < 2) step();
        end
    endtask

    task automatic test_add();
        logic [14:0] exp_v [6] = '{E_DECODE, E_GETA, E_GETB, E_COMP_ADD, E_WREG, E_WAIT};
        int low_cycles;
        issue(3'b101, 2'b00);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (obs() !== exp_v[i]) begin
                n_fail++;
                $display("FAIL add[%0d]: got %b expected %b", i, obs(), exp_v[i]);
            end
            if (i < 5) step();
        end
        step();
        issue(3'b101, 2'b00);
        low_cycles = 0;
        while (w !== 1'b1 && low_cycles < 20) begin
            low_cycles++;
            step();
        end
        n_checks++;
        if (low_cycles !== 5) begin
            n_fail++;
            $display("FAIL add_w_low_cycles: got %0d expected 5", low_cycles);
        end
    endtask

    task automatic test_and();
        logic [14:0] exp_v [6] = '{E_DECODE, E_GETA, E_GETB, E_COMP_AND, E_WREG, E_WAIT};
        issue(3'b101, 2'b10);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (obs() !== exp_v[i]) begin
                n_fail++;
                $display("FAIL and[%0d]: got %b expected %b", i, obs(), exp_v[i]);
            end
            if (i < 5) step();
        end
    endtask

    task automatic test_cmp();
        logic [14:0] exp_v [5] = '{E_DECODE, E_GETA, E_GETB, E_CMPS, E_WAIT};
        int low_cycles;
        issue(3'b101, 2'b01);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (obs() !== exp_v[i]) begin
                n_fail++;
                $display("FAIL cmp[%0d]: got %b expected %b", i, obs(), exp_v[i]);
            end
            if (i < 4) step();
        end
        step();
        issue(3'b101, 2'b01);
        low_cycles = 0;
        while (w !== 1'b1 && low_cycles < 20) begin
            low_cycles++;
            step();
        end
        n_checks++;
        if (low_cycles !== 4) begin
            n_fail++;
            $display("FAIL cmp_w_low_cycles: got %0d expected 4", low_cycles);
        end
    endtask

    task automatic test_mvn();
        logic [14:0] exp_v [5] = '{E_DECODE, E_GETB, E_COMP_MVN, E_WREG, E_WAIT};
        issue(3'b101, 2'b11);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (obs() !== exp_v[i]) begin
                n_fail++;
                $display("FAIL mvn[%0d]: got %b expected %b", i, obs(), exp_v[i]);
            end
            if (i < 4) step();
        end
    endtask

    task automatic test_mov_reg();
        logic [14:0] exp_v [5] = '{E_DECODE, E_GETB, E_COMP_MOV, E_WREG, E_WAIT};
        issue(3'b110, 2'b00);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (obs() !== exp_v[i]) begin
                n_fail++;
                $display("FAIL mov_reg[%0d]: got %b expected %b", i, obs(), exp_v[i]);
            end
            if (i < 4) step();
        end
    endtask

    task automatic test_illegal();
        logic [14:0] exp_v [2] = '{E_DECODE, E_WAIT};
        issue(3'b011, 2'b00);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs() !== exp_v[i]) begin
                n_fail++;
                $display("FAIL illegal[%0d]: got %b expected %b", i, obs(), exp_v[i]);
            end
            if (i < 1) step();
        end
    endtask

    // Inputs change to an illegal opcode during GET_B; the captured ADD
    // must run to completion unchanged.
    task automatic test_input_change();
        logic [14:0] exp_v [6] = '{E_DECODE, E_GETA, E_GETB, E_COMP_ADD, E_WREG, E_WAIT};
        issue(3'b101, 2'b00);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (obs() !== exp_v[i]) begin
                n_fail++;
                $display("FAIL add_input_change[%0d]: got %b expected %b", i, obs(), exp_v[i]);
            end
            if (i == 2) begin
                opcode = 3'b000;
                op     = 2'b11;
            end
            if (i < 5) step();
        end
    endtask

    task automatic test_reset_mid();
        logic [14:0] exp_v [4] = '{E_DECODE, E_GETA, E_GETB, E_COMP_ADD};
        issue(3'b101, 2'b00);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs() !== exp_v[i]) begin
                n_fail++;
                $display("FAIL reset_mid_pre[%0d]: got %b expected %b", i, obs(), exp_v[i]);
            end
            if (i < 3) step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs() !== E_WAIT) begin
                n_fail++;
                $display("FAIL reset_mid_wait[%0d]: got %b expected %b", i, obs(), E_WAIT);
            end
            step();
        end
    endtask

    // s held high through two MOV imm instructions: WAIT must appear for a
    // full cycle between them, and s during non-WAIT states is not queued.
    task automatic test_back_to_back();
        logic [14:0] exp_v [7] = '{E_DECODE, E_WIMM, E_WAIT, E_DECODE, E_WIMM, E_WAIT, E_WAIT};
        opcode = 3'b110;
        op     = 2'b10;
        s      = 1'b1;
        step();
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (obs() !== exp_v[i]) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %b expected %b", i, obs(), exp_v[i]);
            end
            if (i == 5) s = 1'b0;
            if (i < 6) step();
        end
    endtask

    initial begin
        reset  = 1'b1;
        s      = 1'b0;
        opcode = 3'b000;
        op     = 2'b00;
        test_reset();
        test_mov_imm();
        test_add();
        test_and();
        test_cmp();
        test_mvn();
        test_mov_reg();
        test_illegal();
        test_input_change();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fsm.md
# instr_fsm

Multi-cycle control FSM for the simple RISC datapath; it sits directly upstream of the ALU and register file. On a start pulse it latches the instruction's opcode and op fields, then sequences register-file reads into the A/B operand registers, selects the ALU operation and operand muxes, and writes the result back or updates the status register. It drives the ALU's 2-bit operation select and the datapath load/select strobes.

## Interface
Parameters:
- none (all widths fixed by the 16-bit ISA)

Ports (synchronous reset, active-high; single clock):
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high; forces WAIT state
- s  in  1  start request, sampled only in WAIT
- opcode  in  3  instruction bits [15:13], latched when s accepted
- op  in  2  instruction bits [12:11], latched when s accepted
- w  out  1  high when idle in WAIT and ready for s
- nsel  out  3  one-hot register select: 001=Rn, 010=Rd, 100=Rm, 000=none
- vsel  out  2  write-back source: 00=C register, 01=sign-extended imm8
- write  out  1  register-file write enable
- loada  out  1  load A operand register
- loadb  out  1  load B operand register
- asel  out  1  1 forces ALU A input to 16'h0000
- bsel  out  1  always 0 for this ISA subset (shifted B path)
- loadc  out  1  load C result register
- loads  out  1  load status register (Z)
- alu_op  out  2  ALU operation select: 00 add, 01 sub, 10 and, 11 not-B

## Operation
- Decoded instructions (opcode_q, op_q):
  - 110/10 MOV Rn,#imm8: WAIT→DECODE→WRITE_IMM→WAIT.
  - 110/00 MOV Rd,Rm: WAIT→DECODE→GET_B→COMPUTE→WRITE_REG→WAIT.
  - 101/00 ADD, 101/10 AND: WAIT→DECODE→GET_A→GET_B→COMPUTE→WRITE_REG→WAIT.
  - 101/01 CMP: WAIT→DECODE→GET_A→GET_B→CMP_S→WAIT.
  - 101/11 MVN: same path as MOV Rd,Rm.
  - Anything else: DECODE→WAIT; no strobe asserted.
- Moore outputs; every output is 0 in each state unless listed:
  - WAIT: w=1.
  - DECODE: all 0.
  - WRITE_IMM: nsel=001, vsel=01, write=1.
  - GET_A: nsel=001, loada=1.
  - GET_B: nsel=100, loadb=1.
  - COMPUTE: loadc=1; asel=1 for opcode 110 and for MVN; alu_op=op_q.
  - CMP_S: loads=1, alu_op=01, asel=0.
  - WRITE_REG: nsel=010, vsel=00, write=1.
- opcode_q/op_q load only on the edge where state=WAIT and s=1. Later changes to opcode, op, or s have no effect until the FSM returns to WAIT.
- alu_op is 00 in every state other than COMPUTE and CMP_S.

## Timing
- Reset values: state=WAIT, w=1, every other output 0, opcode_q=000, op_q=00.
- If reset is high at a rising edge, the FSM is in WAIT after that edge. This holds in every state, including mid-instruction: no write or loads is issued after that edge. Reset wins over a simultaneous s.
- Cycles with w low, counted from the edge that samples s: MOV imm 2, MOV reg/MVN 4, CMP 4, ADD/AND 5, illegal 1.
- Back-to-back: if s=1 on the edge that returns to WAIT, it is not sampled. WAIT lasts at least one full cycle with w=1, and s is then sampled on the following edge.
- write is high for exactly one cycle per writing instruction; CMP never asserts write or loadc; only CMP asserts loads.
- s=1 while not in WAIT is ignored; the instruction is not queued.

## Test plan
- Reset with s=1: w=1 and all strobes 0 after the edge. Pulse s with opcode=110, op=10: next cycle DECODE (all 0); then nsel=001, vsel=01, write=1 for one cycle; then w=1.
- ADD (101/00): observe the sequence loada+nsel=001 → loadb+nsel=100 → loadc, alu_op=00, asel=0 → write, nsel=010, vsel=00 → w=1. Then 5 cycles with w low.
- CMP (101/01): loads=1 with alu_op=01 for exactly one cycle. write and loadc stay 0 throughout; w is low for 4 cycles.
- MVN (101/11) and MOV Rd,Rm (110/00): no loada cycle. COMPUTE shows asel=1 with alu_op=11 and 00 respectively; write occurs on the next cycle.
- Illegal opcode 011: exactly one cycle with w low and no strobes. Change opcode to 000 during GET_B of an ADD: the sequence is unchanged.
- Assert reset during COMPUTE of an ADD: the next cycle is WAIT, w=1, and write never asserts. Hold s=1 continuously: an instruction starts only from WAIT, with w=1 for at least one full cycle between instructions.
